dnn_result_collector: RTL and testbench
=======================================

DNN_RESULT_COLLECTOR -- requirements
Module: dnn_result_collector

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 out0  input  17  signed two's-complement score, class 0, from dnn_opt_mult.
REQ-004 out1  input  17  signed two's-complement score, class 1, from dnn_opt_mult.
REQ-005 out0_ready  input  1  out0 valid this cycle (single-cycle pulse).
REQ-006 out1_ready  input  1  out1 valid this cycle (single-cycle pulse).
REQ-007 res_valid  output  1  FIFO head entry valid.
REQ-008 res_ready  input  1  consumer accepts head entry.
REQ-009 res_class  output  1  argmax class of head entry.
REQ-010 res_value  output  17  signed winning score of head entry.
REQ-011 res_tie  output  1  head entry had out0 == out1.
REQ-012 res_count  output  3  FIFO occupancy, 0..4.
REQ-013 overflow  output  1  sticky: result dropped because FIFO was full.

Function
REQ-014 Pair capture FSM SHALL have states WAIT (none held), HAVE0 (out0 held), HAVE1 (out1 held).
REQ-015 WAIT: out0_ready only -> latch out0, go to HAVE0; out1_ready only -> latch out1, go to HAVE1; both asserted -> pair complete, stay WAIT.
REQ-016 HAVE0: out1_ready -> pair complete with held out0, go to WAIT; a repeated out0_ready without out1_ready overwrites held out0 (latest wins), stay HAVE0.
REQ-017 HAVE1: symmetric to HAVE0.
REQ-018 HAVE0 or HAVE1 with both readies asserted: use incoming values for both scores, pair complete, go to WAIT.
REQ-019 Argmax SHALL be a signed 17-bit compare: class=1 and value=out1 iff out1 > out0; otherwise class=0, value=out0; tie=1 iff out0 == out1.
REQ-020 On pair completion at edge N, the entry SHALL be written to the FIFO at edge N; res_valid is high after edge N when the FIFO was empty (1-cycle latency from the final ready sample).
REQ-021 FIFO SHALL be 4 entries, first-word fall-through; res_class/res_value/res_tie reflect the head whenever res_valid=1.
REQ-022 Pop SHALL occur at an edge where res_valid && res_ready; when empty, res_ready is ignored.
REQ-023 Push when full with no pop SHALL drop the new entry, leave contents unchanged, and set overflow=1 until reset.
REQ-024 Simultaneous push and pop when full SHALL accept both; occupancy stays 4; overflow unchanged.
REQ-025 Simultaneous push and pop when empty SHALL perform the push only; the entry appears after the edge.
REQ-026 res_count SHALL equal the number of stored entries after every edge; read/write pointers wrap modulo 4.
REQ-027 When res_valid=0, res_class, res_value and res_tie SHALL be driven 0.

Reset
REQ-028 rst=1 SHALL immediately force: FSM=WAIT, held scores=0, FIFO empty, pointers=0, res_valid=0, res_class=0, res_value=0, res_tie=0, res_count=0, overflow=0.
REQ-029 Reset mid-pair or mid-drain SHALL discard the held score and all FIFO contents; after deassertion, the first readies start a fresh pair.

Structure
REQ-030 Shared package dnn_pkg SHALL hold OUT_W=17, RES_FIFO_DEPTH=4, the FSM state enum, and the result record type {class, tie, value}.
REQ-031 FIFO storage and pointers SHALL be a sub-module dnn_result_fifo (parameterised depth, result record payload, full/empty/count).

Verification
REQ-032 Both readies, out0=-726, out1=-348 -> one cycle later res_valid=1, class=1, value=-348, tie=0, count=1.
REQ-033 out0_ready with out0=1173, then 3 cycles later out1_ready with out1=1392 -> one entry, class=1, value=1392; FSM back in WAIT.
REQ-034 Both readies, out0=out1=-65536 -> class=0, value=-65536, tie=1; repeat with 54000 -> class=0, value=54000, tie=1.
REQ-035 res_ready=0, five complete pairs with out0=1..5, out1=0 -> count=4, overflow=1, drain yields values 1,2,3,4, then res_valid=0.
REQ-036 FIFO full, with res_ready=1 and a pair completing on the same edge -> count stays 4, overflow stays 0, head advances.
REQ-037 Assert rst while in HAVE0 with 2 entries queued -> all outputs 0 immediately; after release, a single out1_ready produces no entry.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared types and constants for the DNN result collector: score width, FIFO depth,
// pair-capture states and the stored result record.
package dnn_pkg;

    localparam int OUT_W          = 17;
    localparam int RES_FIFO_DEPTH = 4;
    localparam int CNT_W          = $clog2(RES_FIFO_DEPTH + 1);

    typedef logic signed [OUT_W-1:0] score_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_HAVE0 = 2'd1,
        ST_HAVE1 = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic   cls;
        logic   tie;
        score_t value;
    } result_t;

    // Ties resolve to class 0, so class 1 wins only on a strict signed greater-than.
    function automatic result_t argmax(input score_t s0, input score_t s1);
        result_t r;
        r.cls   = (s1 > s0);
        r.value = r.cls ? s1 : s0;
        r.tie   = (s0 == s1);
        return r;
    endfunction

endpackage

// File: rtl/dnn_result_collector_if.sv
// Score inputs from dnn_opt_mult and the result-queue handshake toward the consumer.
interface dnn_result_collector_if;
    import dnn_pkg::*;

    score_t           out0;
    score_t           out1;
    logic             out0_ready;
    logic             out1_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_class;
    score_t           res_value;
    logic             res_tie;
    logic [CNT_W-1:0] res_count;
    logic             overflow;

    modport master (
        output out0, out1, out0_ready, out1_ready, res_ready,
        input  res_valid, res_class, res_value, res_tie, res_count, overflow
    );

    modport slave (
        input  out0, out1, out0_ready, out1_ready, res_ready,
        output res_valid, res_class, res_value, res_tie, res_count, overflow
    );

endinterface

// File: rtl/dnn_result_fifo.sv
// First-word fall-through result queue with modulo-DEPTH pointers and occupancy count.
module dnn_result_fifo
    import dnn_pkg::*;
#(
    parameter int DEPTH = RES_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  result_t                      din,
    input  logic                         pop,
    output result_t                      head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // A pop on the same edge frees the slot, so a full queue still takes the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dnn_result_collector.sv
// Pairs class-0/class-1 scores arriving on independent strobes, takes the argmax and
// queues {class, tie, value} records for a ready/valid consumer.
module dnn_result_collector
    import dnn_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    dnn_result_collector_if.slave bus
);

    cap_state_e       state_q, state_d;
    score_t           held0_q, held0_d;
    score_t           held1_q, held1_d;
    score_t           s0, s1;
    logic             pair_done;
    logic             overflow_q;
    result_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        state_d   = state_q;
        held0_d   = held0_q;
        held1_d   = held1_q;
        pair_done = 1'b0;
        s0        = bus.out0;
        s1        = bus.out1;
        case (state_q)
            ST_WAIT: begin
                if (bus.out0_ready && bus.out1_ready) begin
                    pair_done = 1'b1;
                end else if (bus.out0_ready) begin
                    held0_d = bus.out0;
                    state_d = ST_HAVE0;
                end else if (bus.out1_ready) begin
                    held1_d = bus.out1;
                    state_d = ST_HAVE1;
                end
            end
            // Fresh scores arriving together always beat a held one.
            ST_HAVE0: begin
                if (bus.out1_ready) begin
                    pair_done = 1'b1;
                    s0        = bus.out0_ready ? bus.out0 : held0_q;
                    state_d   = ST_WAIT;
                end else if (bus.out0_ready) begin
                    held0_d = bus.out0;
                end
            end
            ST_HAVE1: begin
                if (bus.out0_ready) begin
                    pair_done = 1'b1;
                    s1        = bus.out1_ready ? bus.out1 : held1_q;
                    state_d   = ST_WAIT;
                end else if (bus.out1_ready) begin
                    held1_d = bus.out1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            held0_q    <= '0;
            held1_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            held0_q <= held0_d;
            held1_q <= held1_d;
            // A full queue only loses the new entry when nothing drains on this edge.
            if (pair_done && fifo_full && !bus.res_ready) overflow_q <= 1'b1;
        end
    end

    dnn_result_fifo #(
        .DEPTH (RES_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pair_done),
        .din   (argmax(s0, s1)),
        .pop   (bus.res_ready),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.res_valid = !fifo_empty;
    assign bus.res_class = !fifo_empty && fifo_head.cls;
    assign bus.res_tie   = !fifo_empty && fifo_head.tie;
    assign bus.res_value = fifo_empty ? '0 : fifo_head.value;
    assign bus.res_count = fifo_count;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_dnn_result_collector.sv
// Directed bench for dnn_result_collector: per-cycle vector table plus sequences for
// queue full/overflow behaviour and asynchronous reset mid-pair.
module tb_dnn_result_collector;
    import dnn_pkg::*;

    typedef struct {
        bit r0;
        bit r1;
        int o0;
        int o1;
        bit rr;
        bit ev;
        bit ec;
        int eval;
        bit et;
        int ecnt;
        bit eovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs [22];

    dnn_result_collector_if bus ();

    dnn_result_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r0, bit r1, int o0, int o1, bit rr,
                                bit ev, bit ec, int eval, bit et, int ecnt, bit eovf);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.o0 = o0; v.o1 = o1; v.rr = rr;
        v.ev = ev; v.ec = ec; v.eval = eval; v.et = et; v.ecnt = ecnt; v.eovf = eovf;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_out(input string tag, input int ev, input int ec, input int eval,
                             input int et, input int ecnt, input int eovf);
        check({tag, ".valid"}, int'(bus.res_valid), ev);
        check({tag, ".class"}, int'(bus.res_class), ec);
        check({tag, ".value"}, int'(bus.res_value), eval);
        check({tag, ".tie"},   int'(bus.res_tie),   et);
        check({tag, ".count"}, int'(bus.res_count), ecnt);
        check({tag, ".ovf"},   int'(bus.overflow),  eovf);
    endtask

    task automatic drive(input bit r0, input bit r1, input int o0, input int o1, input bit rr);
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        bus.out0       = o0[OUT_W-1:0];
        bus.out1       = o1[OUT_W-1:0];
        bus.res_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int n, input int first, input int step);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.head%0d", tag, k), int'(bus.res_value), first + k * step);
            drive(0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        //            r0 r1  o0      o1     rr   ev ec  val     et cnt ovf
        vecs[0]  = mk(1, 1, -726,   -348,   0,   1, 1, -348,   0, 1, 0);
        vecs[1]  = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);
        vecs[2]  = mk(1, 0, 1173,   0,      0,   0, 0, 0,      0, 0, 0);
        vecs[3]  = mk(0, 0, 0,      0,      0,   0, 0, 0,      0, 0, 0);
        vecs[4]  = mk(0, 0, 0,      0,      0,   0, 0, 0,      0, 0, 0);
        vecs[5]  = mk(0, 1, 0,      1392,   0,   1, 1, 1392,   0, 1, 0);
        vecs[6]  = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);
        vecs[7]  = mk(1, 1, -65536, -65536, 0,   1, 0, -65536, 1, 1, 0);
        vecs[8]  = mk(1, 1, 54000,  54000,  1,   1, 0, 54000,  1, 1, 0);
        vecs[9]  = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);
        vecs[10] = mk(1, 0, 10,     0,      0,   0, 0, 0,      0, 0, 0);
        vecs[11] = mk(1, 0, 20,     0,      0,   0, 0, 0,      0, 0, 0);
        vecs[12] = mk(0, 1, 0,      15,     0,   1, 0, 20,     0, 1, 0);
        vecs[13] = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);
        vecs[14] = mk(0, 1, 0,      100,    0,   0, 0, 0,      0, 0, 0);
        vecs[15] = mk(1, 1, 5,      3,      0,   1, 0, 5,      0, 1, 0);
        vecs[16] = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);
        vecs[17] = mk(0, 1, 0,      -2,     0,   0, 0, 0,      0, 0, 0);
        vecs[18] = mk(1, 0, -7,     0,      0,   1, 1, -2,     0, 1, 0);
        vecs[19] = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);
        vecs[20] = mk(1, 1, 3,      9,      1,   1, 1, 9,      0, 1, 0);
        vecs[21] = mk(0, 0, 0,      0,      1,   0, 0, 0,      0, 0, 0);

        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].r1, vecs[i].o0, vecs[i].o1, vecs[i].rr);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].eval,
                      vecs[i].et, vecs[i].ecnt, vecs[i].eovf);
        end
        drive(0, 0, 0, 0, 0);

        // Fill to 4, then push and pop on the same edge.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 10 * k, 0, 0);
            tick();
        end
        check_out("full", 1, 0, 10, 0, 4, 0);
        drive(1, 1, 50, 0, 1);
        tick();
        check_out("full_pushpop", 1, 0, 20, 0, 4, 0);
        drain("drainA", 4, 20, 10);
        check_out("drainA.end", 0, 0, 0, 0, 0, 0);

        // Five pairs into a 4-deep queue with no consumer.
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, k, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        check_out("overflow", 1, 0, 1, 0, 4, 1);
        drain("drainB", 4, 1, 1);
        check_out("drainB.end", 0, 0, 0, 0, 0, 1);

        // Reset clears overflow, then reset again while holding out0 with two entries queued.
        rst = 1'b1;
        #1;
        check("rst1.ovf", int'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 7, 8, 0);
        tick();
        drive(1, 1, 9, 2, 0);
        tick();
        drive(1, 0, 33, 0, 0);
        tick();
        check_out("pre_rst", 1, 1, 8, 0, 2, 0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_out("rst_async", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0, 500, 0);
        tick();
        check_out("after_rst", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
